ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader_pkg.sv | 21 ++
 rtl/ccff_readback_collector.sv | 50 +++++
 rtl/ccff_chain_loader.sv | 99 +++++++++
 tb/tb_ccff_chain_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared configuration-protocol definitions: loader FSM encoding and a
// constant-friendly ceil(log2) helper for counter sizing.
package ccff_chain_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ld_state_e;

  // Returns ceil(log2(v)) with a floor of 1 so counters are never zero-width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ccff_readback_collector.sv
// Collects bits returned from the chain tail into words, first-out bit in MSB;
// a short final word is left-aligned with zero fill.
module ccff_readback_collector
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              last,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
);

  localparam int WW = clog2(WORD_W + 1);

  logic [WORD_W-1:0] acc, acc_nxt;
  logic [WW-1:0]     cnt, shamt;
  logic              full;

  assign acc_nxt = (acc << 1) | WORD_W'(bit_in);
  assign full    = (cnt == WW'(WORD_W - 1));
  // bits collected this edge are cnt+1, so pad by WORD_W-(cnt+1)
  assign shamt   = WW'(WORD_W - 1) - cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      rb_word  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (shift_en) begin
        if (full || last) begin
          rb_word  <= acc_nxt << shamt;
          rb_valid <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + WW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first into a configuration flip-flop chain and
// returns the displaced old chain contents as readback words.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 12
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_clk_en,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int CW = clog2(CHAIN_LEN + 1);
  localparam int WW = clog2(WORD_W + 1);

  ld_state_e         state, state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [CW-1:0]     bits_shifted;
  logic [WW-1:0]     word_left, word_len;
  logic [31:0]       remaining;
  logic              xfer, last_bit, word_end;

  assign xfer      = word_valid & word_ready;
  assign last_bit  = (32'(bits_shifted) == 32'(CHAIN_LEN - 1));
  assign word_end  = (word_left == WW'(1));
  assign remaining = 32'(CHAIN_LEN) - 32'(bits_shifted);
  // the final word may be partial; its low bits are never shifted
  assign word_len  = (remaining < 32'(WORD_W)) ? WW'(remaining) : WW'(WORD_W);
  assign ccff_head = cfg_clk_en & sreg[WORD_W-1];

  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    cfg_clk_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        cfg_clk_en = 1'b1;
        if (last_bit)      state_nxt = DONE;
        else if (word_end) state_nxt = FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state        <= IDLE;
      sreg         <= '0;
      bits_shifted <= '0;
      word_left    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) bits_shifted <= '0;
      if (xfer) begin
        sreg      <= word_in;
        word_left <= word_len;
      end else if (cfg_clk_en) begin
        sreg         <= sreg << 1;
        bits_shifted <= bits_shifted + CW'(1);
        word_left    <= word_left - WW'(1);
      end
    end
  end

  ccff_readback_collector #(.WORD_W(WORD_W)) u_rb (
    .clk      (prog_clk),
    .rst      (pReset),
    .shift_en (cfg_clk_en),
    .bit_in   (ccff_tail),
    .last     (cfg_clk_en & last_bit),
    .rb_word  (rb_word),
    .rb_valid (rb_valid)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed scoreboard bench: a 12-bit and an 8-bit chain model behind two
// loader instances; expected head bits and readback words are queued at drive time.
module tb_ccff_chain_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic pReset;
  logic start_a, word_valid_a, word_ready_a, head_a, tail_a, en_a, rb_valid_a, busy_a, done_a;
  logic [7:0] word_in_a, rb_word_a;
  logic start_b, word_valid_b, word_ready_b, head_b, tail_b, en_b, rb_valid_b, busy_b, done_b;
  logic [7:0] word_in_b, rb_word_b;
  logic [11:0] chain_a;
  logic [7:0]  chain_b;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .word_in(word_in_a),
    .word_valid(word_valid_a), .word_ready(word_ready_a), .ccff_head(head_a),
    .ccff_tail(tail_a), .cfg_clk_en(en_a), .rb_word(rb_word_a), .rb_valid(rb_valid_a),
    .busy(busy_a), .done(done_a));

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(8)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .word_in(word_in_b),
    .word_valid(word_valid_b), .word_ready(word_ready_b), .ccff_head(head_b),
    .ccff_tail(tail_b), .cfg_clk_en(en_b), .rb_word(rb_word_b), .rb_valid(rb_valid_b),
    .busy(busy_b), .done(done_b));

  // chain models: preloaded under reset, shift only on enabled edges
  always @(posedge prog_clk) begin
    if (pReset) begin
      chain_a <= 12'hFFF;
      chain_b <= 8'h00;
    end else begin
      if (en_a) chain_a <= {chain_a[10:0], head_a};
      if (en_b) chain_b <= {chain_b[6:0], head_b};
    end
  end
  assign tail_a = chain_a[11];
  assign tail_b = chain_b[7];

  int tests = 0, fails = 0;
  logic hq_a[$], hq_b[$];
  logic [7:0] rq_a[$], rq_b[$];
  int shifts_a = 0, dones_a = 0, rbv_a = 0;
  int shifts_b = 0, dones_b = 0, rbv_b = 0, fetch_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    if (en_a) begin
      shifts_a++;
      if (hq_a.size() == 0) check("head_a_underflow", 32'(hq_a.size()), 1);
      else check("head_a", 32'(head_a), 32'(hq_a.pop_front()));
    end else check("head_a_idle0", 32'(head_a), 0);
    if (rb_valid_a) begin
      rbv_a++;
      if (rq_a.size() == 0) check("rb_a_underflow", 32'(rq_a.size()), 1);
      else check("rb_a", 32'(rb_word_a), 32'(rq_a.pop_front()));
    end
    if (done_a) dones_a++;
    if (en_b) begin
      shifts_b++;
      if (hq_b.size() == 0) check("head_b_underflow", 32'(hq_b.size()), 1);
      else check("head_b", 32'(head_b), 32'(hq_b.pop_front()));
    end else check("head_b_idle0", 32'(head_b), 0);
    if (rb_valid_b) begin
      rbv_b++;
      if (rq_b.size() == 0) check("rb_b_underflow", 32'(rq_b.size()), 1);
      else check("rb_b", 32'(rb_word_b), 32'(rq_b.pop_front()));
    end
    if (done_b) dones_b++;
    if (word_ready_b) fetch_b++;
  endtask

  // advance one cycle; inputs change and outputs are sampled at the falling edge
  task automatic step();
    @(posedge prog_clk);
    @(negedge prog_clk);
    mon();
  endtask

  task automatic push_head_a(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) hq_a.push_back(w[i]);
  endtask

  task automatic send_a(input logic [7:0] w);
    int n;
    n = 0;
    word_in_a = w;
    word_valid_a = 1'b1;
    while (!word_ready_a && n < 50) begin step(); n++; end
    check("ready_a_timeout", 32'(word_ready_a), 1);
    step();
    word_valid_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (!done_a && n < 100) begin step(); n++; end
    check("done_a_timeout", 32'(done_a), 1);
  endtask

  initial begin
    logic [11:0] snap;
    int s0, d0, r0, n;
    pReset = 1'b1;
    start_a = 0; word_valid_a = 0; word_in_a = '0;
    start_b = 0; word_valid_b = 0; word_in_b = '0;
    step(); step();

    // reset state
    check("rst_word_ready", 32'(word_ready_a), 0);
    check("rst_head", 32'(head_a), 0);
    check("rst_cfg_clk_en", 32'(en_a), 0);
    check("rst_rb_word", 32'(rb_word_a), 0);
    check("rst_rb_valid", 32'(rb_valid_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);

    // start together with reset stays idle
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    pReset = 1'b0;
    step();
    check("rst_start_busy", 32'(busy_a), 0);
    check("rst_start_ready", 32'(word_ready_a), 0);

    // 12-bit load of 0xA5, 0x3C over a chain preloaded with 0xFFF
    push_head_a(8'hA5, 8);
    push_head_a(8'h3C, 4);
    rq_a.push_back(8'hFF);
    rq_a.push_back(8'hF0);
    s0 = shifts_a; d0 = dones_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    send_a(8'hA5);
    start_a = 1'b1;                     // ignored while busy
    step();
    start_a = 1'b0;
    n = 0;
    while (!word_ready_a && n < 50) begin step(); n++; end
    check("fetch2_timeout", 32'(word_ready_a), 1);
    snap = chain_a;
    for (int i = 0; i < 5; i++) begin
      check("stall_en", 32'(en_a), 0);
      check("stall_chain", 32'(chain_a), 32'(snap));
      step();
    end
    send_a(8'h3C);
    wait_done_a();
    check("t1_shifts", 32'(shifts_a - s0), 12);
    check("t1_chain", 32'(chain_a), 32'h0A53);
    check("t1_head_q_empty", 32'(hq_a.size()), 0);
    check("t1_rb_q_empty", 32'(rq_a.size()), 0);
    step(); step(); step();
    check("t1_done_once", 32'(dones_a - d0), 1);
    check("t1_busy_after", 32'(busy_a), 0);
    check("t1_ready_after", 32'(word_ready_a), 0);

    // single-word chain: CHAIN_LEN=8, word 0x81
    for (int i = 7; i >= 0; i--) hq_b.push_back(i == 7 || i == 0);
    rq_b.push_back(8'h00);
    start_b = 1'b1;
    word_in_b = 8'h81;
    word_valid_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    word_valid_b = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin step(); n++; end
    check("done_b_timeout", 32'(done_b), 1);
    step(); step();
    check("t2_shifts", 32'(shifts_b), 8);
    check("t2_fetch", 32'(fetch_b), 1);
    check("t2_rb_valid", 32'(rbv_b), 1);
    check("t2_done", 32'(dones_b), 1);
    check("t2_chain", 32'(chain_b), 32'h81);
    check("t2_busy", 32'(busy_b), 0);

    // reset after five shifted bits abandons the load
    push_head_a(8'hA5, 8);
    d0 = dones_a; r0 = rbv_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    send_a(8'hA5);
    for (int i = 0; i < 5; i++) step();
    pReset = 1'b1;
    step();
    check("abort_busy", 32'(busy_a), 0);
    check("abort_en", 32'(en_a), 0);
    check("abort_done", 32'(done_a), 0);
    check("abort_rb_valid", 32'(rb_valid_a), 0);
    pReset = 1'b0;
    hq_a.delete();
    step(); step(); step();
    check("abort_no_done", 32'(dones_a - d0), 0);
    check("abort_no_rb", 32'(rbv_a - r0), 0);
    check("abort_idle", 32'(busy_a), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
